// File: rtl/booth_mul_scheduler.sv
// rtl/booth_mul_scheduler.sv - round-robin scheduler sharing one booth multiplier between two ports
module booth_mul_scheduler #(
    parameter int TIMEOUT_CYCLES = 32,
    parameter int LOAD_CYCLES    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [7:0]  a0,
    input  logic [7:0]  b0,
    output logic        ack0,
    output logic [15:0] result0,
    input  logic        req1,
    input  logic [7:0]  a1,
    input  logic [7:0]  b1,
    output logic        ack1,
    output logic [15:0] result1,
    output logic        mul_en,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [15:0] mul_result,
    input  logic        mul_ready,
    output logic        busy,
    output logic        grant,
    output logic        timeout_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW = $clog2(LOAD_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t         state_q, state_d;
    logic           grant_q, grant_d;
    // prio_q names the port that wins a tie; it flips to the other port after each service
    logic           prio_q, prio_d;
    logic [7:0]     a_q, a_d, b_q, b_d;
    logic [LW-1:0]  load_cnt_q, load_cnt_d;
    logic [CW-1:0]  run_cnt_q, run_cnt_d;
    logic [15:0]    result0_q, result0_d, result1_q, result1_d;
    logic           to_q, to_d;
    logic           pick;

    logic load_last;
    logic run_last;
    assign load_last = (load_cnt_q == LW'(LOAD_CYCLES - 1));
    assign run_last  = (run_cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Arbitration choice made in IDLE: tie goes to the prioritised port, otherwise the sole requester
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = prio_q;
        end else begin
            pick = req1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req0 || req1) state_d = S_LOAD;
            S_LOAD: if (load_last) state_d = S_RUN;
            S_RUN:  if (mul_ready || run_last) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: grant/operand latch, phase counters, result capture, priority update
    always_comb begin
        grant_d    = grant_q;
        prio_d     = prio_q;
        a_d        = a_q;
        b_d        = b_q;
        load_cnt_d = load_cnt_q;
        run_cnt_d  = run_cnt_q;
        result0_d  = result0_q;
        result1_d  = result1_q;
        to_d       = to_q;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    grant_d    = pick;
                    a_d        = pick ? a1 : a0;
                    b_d        = pick ? b1 : b0;
                    load_cnt_d = '0;
                    to_d       = 1'b0;
                end
            end
            S_LOAD: begin
                if (load_last) begin
                    run_cnt_d = '0;
                end else begin
                    load_cnt_d = load_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (mul_ready) begin
                    if (grant_q) result1_d = mul_result;
                    else         result0_d = mul_result;
                end else if (run_last) begin
                    if (grant_q) result1_d = 16'h0000;
                    else         result0_d = 16'h0000;
                    to_d = 1'b1;
                end else begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                prio_d = ~grant_q;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q    <= 1'b0;
            prio_q     <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            load_cnt_q <= '0;
            run_cnt_q  <= '0;
            result0_q  <= '0;
            result1_q  <= '0;
            to_q       <= 1'b0;
        end else begin
            grant_q    <= grant_d;
            prio_q     <= prio_d;
            a_q        <= a_d;
            b_q        <= b_d;
            load_cnt_q <= load_cnt_d;
            run_cnt_q  <= run_cnt_d;
            result0_q  <= result0_d;
            result1_q  <= result1_d;
            to_q       <= to_d;
        end
    end

    // Outputs decoded from state so they fall together with an asynchronous reset
    always_comb begin
        mul_en      = (state_q == S_RUN);
        busy        = (state_q != S_IDLE);
        ack0        = (state_q == S_DONE) && !grant_q;
        ack1        = (state_q == S_DONE) && grant_q;
        timeout_err = (state_q == S_DONE) && to_q;
        grant       = grant_q;
        mul_a       = a_q;
        mul_b       = b_q;
        result0     = result0_q;
        result1     = result1_q;
    end

endmodule
